// File: rtl/stop_watch_pkg.sv
// Shared definitions for the stopwatch: FSM state encoding and the
// display-field limits used by the counters and by the top level.
package stop_watch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // after reset, count held at 0:00
        RUN   = 2'd1,   // counting
        PAUSE = 2'd2    // count frozen
    } state_e;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 3;
    localparam int SEC_N   = SEC_MAX + 1;
    localparam int MIN_N   = MIN_MAX + 1;
    localparam int SEC_W   = 6;
    localparam int MIN_W   = 2;

endpackage

// File: rtl/stop_watch_mod_counter.sv
// Modulo-N counter with enable, carry-out and async active-low clear.
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low clear (count -> 0)
//   en_i     advance the count by one on this edge
//   count_o  registered count, 0..N-1
//   carry_o  high in the cycle whose enabled edge wraps N-1 -> 0
//            (combinational from en_i so counters can be chained)
module mod_counter #(
    parameter int N = 60,
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         carry_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_max;

    assign at_max = (count_q == W'(N - 1));

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = at_max ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign carry_o = en_i && at_max;

endmodule

// File: rtl/stop_watch.sv
// Minutes/seconds stopwatch, range 0:00..3:59, wrapping to 0:00.
// A prescaler divides clk down to a one-second tick while running.
// Ports:
//   clk        system clock, all state changes on rising edge
//   reset      asynchronous active-low reset (state IDLE, count 0:00)
//   start      level; start or resume counting (ignored while stop=1)
//   stop       level; pause counting, wins over start
//   minute     registered elapsed minutes, 0..3
//   second     registered elapsed seconds within the minute, 0..59
//   state_dbg  current FSM state, for observation only
//
// Handshake/control semantics: start and stop are plain levels sampled
// on each rising edge; there is no valid/ready handshake on this block.
module stop_watch
    import stop_watch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    output logic [MIN_W-1:0] minute,
    output logic [SEC_W-1:0] second,
    output state_e           state_dbg
);

    // At least one bit so TICKS_PER_SEC=1 still has a legal register.
    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    state_e               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 run_en;
    logic                 tick;
    logic                 sec_carry;
    logic                 min_carry;

    // Counting happens only in RUN and not on the edge that samples stop.
    assign run_en = (state_q == RUN) && !stop;
    assign tick   = run_en && (presc_q == PRESC_W'(TICKS_PER_SEC - 1));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                if (start && !stop) state_d = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSE;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                end
            end
            PAUSE: begin
                // prescaler holds so a resume finishes the partial second
                if (start && !stop) state_d = RUN;
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    mod_counter #(
        .N (SEC_N),
        .W (SEC_W)
    ) u_sec (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (tick),
        .count_o (second),
        .carry_o (sec_carry)
    );

    mod_counter #(
        .N (MIN_N),
        .W (MIN_W)
    ) u_min (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (sec_carry),
        .count_o (minute),
        .carry_o (min_carry)
    );

    assign state_dbg = state_q;

    // The minute counter only wraps out of the final second of the range.
    a_full_wrap : assert property (@(posedge clk) disable iff (!reset)
        min_carry |-> (minute == MIN_W'(MIN_MAX) && second == SEC_W'(SEC_MAX)));

endmodule

// File: tb/tb_stop_watch.sv
module tb_stop_watch;
    import stop_watch_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic stop  = 1'b0;

    always #5 clk = ~clk;

    logic [1:0] min_a, min_b;
    logic [5:0] sec_a, sec_b;
    state_e     st_a, st_b;

    stop_watch #(.TICKS_PER_SEC(1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .minute    (min_a),
        .second    (sec_a),
        .state_dbg (st_a)
    );

    stop_watch #(.TICKS_PER_SEC(4)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .minute    (min_b),
        .second    (sec_b),
        .state_dbg (st_b)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Elapsed time is kept as total seconds mod 240; the display fields
    // are derived by division, independent of any counter chaining.
    int     m_tps [2] = '{1, 4};
    state_e m_st  [2];
    int     m_pre [2];
    int     m_secs[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i]   = IDLE;
            m_pre[i]  = 0;
            m_secs[i] = 0;
        end
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_st[i] == RUN && !stop) begin
                    if (m_pre[i] == m_tps[i] - 1) begin
                        m_pre[i]  = 0;
                        m_secs[i] = (m_secs[i] + 1) % 240;
                    end else begin
                        m_pre[i]++;
                    end
                end else if (m_st[i] == IDLE) begin
                    m_pre[i] = 0;
                end
                if (stop) begin
                    if (m_st[i] == RUN) m_st[i] = PAUSE;
                end else if (start && m_st[i] != RUN) begin
                    m_st[i] = RUN;
                end
            end
        end
    endtask

    function automatic logic [15:0] disp(input int secs);
        return 16'((secs / 60) * 64 + (secs % 60));
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_cnt_a"}, {8'd0, min_a, sec_a}, disp(m_secs[0]));
        check({tag, "_cnt_b"}, {8'd0, min_b, sec_b}, disp(m_secs[1]));
        check({tag, "_st_a"},  {14'd0, st_a}, {14'd0, m_st[0]});
        check({tag, "_st_b"},  {14'd0, st_b}, {14'd0, m_st[1]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all(tag);
        end
    endtask

    // Assert reset between clock edges and check it takes effect at once.
    task automatic async_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1;
        check_all("por");
        step(3, "rst_hold");
        reset = 1'b1;
        step(10, "idle");
        check("idle_0m00", {8'd0, min_a, sec_a}, 16'd0);

        // run and minute rollover
        start = 1'b1;
        step(6, "run_start");
        start = 1'b0;
        for (int k = 0; k < 300 && m_secs[0] != 60; k++) step(1, "run");
        check("a_1m00", {8'd0, min_a, sec_a}, 16'd64);
        for (int k = 0; k < 300 && m_secs[0] != 127; k++) step(1, "run");
        check("a_2m07", {8'd0, min_a, sec_a}, 16'd135);

        // pause and resume
        stop = 1'b1;
        step(4, "pause");
        check("a_pause_2m07", {8'd0, min_a, sec_a}, 16'd135);
        stop = 1'b0;
        step(4, "pause_idle");
        check("a_hold_2m07", {8'd0, min_a, sec_a}, 16'd135);
        start = 1'b1;
        step(18, "resume");
        start = 1'b0;

        // full-range wrap
        async_reset("rst_wrap");
        step(1, "rst_wrap_hold");
        reset = 1'b1;
        start = 1'b1;
        step(1, "wrap_start");
        start = 1'b0;
        step(240, "wrap");
        check("a_wrap_0m00", {8'd0, min_a, sec_a}, 16'd0);
        step(1, "wrap_plus1");
        check("a_wrap_0m01", {8'd0, min_a, sec_a}, 16'd1);

        // start/stop conflict, then async reset mid-run
        async_reset("rst_conf");
        step(1, "rst_conf_hold");
        reset = 1'b1;
        start = 1'b1;
        stop  = 1'b1;
        step(5, "conflict");
        check("a_conf_0m00", {8'd0, min_a, sec_a}, 16'd0);
        check("a_conf_idle", {14'd0, st_a}, {14'd0, IDLE});
        stop = 1'b0;
        step(1, "conf_start");
        start = 1'b0;
        step(90, "run90");
        check("a_1m30", {8'd0, min_a, sec_a}, 16'd94);
        #2;
        async_reset("rst_mid");
        check("a_rst_mid_0m00", {8'd0, min_a, sec_a}, 16'd0);
        step(1, "rst_mid_hold");
        reset = 1'b1;
        step(5, "post_rst_idle");

        // prescaler on the 4-cycles-per-second instance
        async_reset("rst_presc");
        step(1, "rst_presc_hold");
        reset = 1'b1;
        start = 1'b1;
        step(1, "presc_start");
        start = 1'b0;
        step(40, "presc_run");
        check("b_0m10", {8'd0, min_b, sec_b}, 16'd10);
        step(2, "presc_part");
        stop = 1'b1;
        step(3, "presc_pause");
        stop  = 1'b0;
        start = 1'b1;
        step(1, "presc_resume");
        start = 1'b0;
        step(12, "presc_after");

        // randomized control traffic
        async_reset("rst_rand");
        step(1, "rst_rand_hold");
        reset = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                async_reset("rand_rst");
            end else begin
                reset = 1'b1;
            end
            step(1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
